gate_truth_table_sequencer: RTL and testbench
=============================================

Name: gate_truth_table_sequencer

Overview:
- Sequencing controller for an external 2-input combinational gate (AND, OR, NAND, ...).
- On a start request, drives the gate inputs x1,x0 through 00, 01, 10, 11 and allows a programmable settle time per combination.
- Samples the gate output z for each combination, assembles the 4-bit truth table, compares it against an expected table latched at start, and reports completion over the soc/eoc handshake.
- Sits between a test/control unit (soc/eoc side) and the gate under exercise (x1/x0/z side).

Parameters:
- SETTLE, 2, clock cycles each input combination is held before z is sampled; legal range 1..15; internal counter is 4 bits.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- soc  in  1  start of conversion; level, sampled on clock edges.
- eoc  out  1  end of conversion; 1 = idle or done, 0 = run in progress.
- expected  in  4  expected truth table; bit i = expected z for {x1,x0}=i; latched at start.
- x1  out  1  gate input, MSB of the current combination.
- x0  out  1  gate input, LSB of the current combination.
- z  in  1  gate output; treated as stable after SETTLE cycles.
- table_out  out  4  measured truth table; bit i = z sampled with {x1,x0}=i.
- pass  out  1  1 if table_out == latched expected; valid while eoc=1 after a completed run.

Behaviour:
- Reset (asynchronous, immediate, any state, including mid-run):
  - state=IDLE, eoc=1, x1=x0=0, table_out=0000, pass=0.
  - Internal index, counter and latched expected are cleared.
- States: IDLE, WAIT, DONE.
- IDLE:
  - eoc=1; outputs hold their last values.
  - On an edge with soc=1:
    - eoc<=0, pass<=0, table_out<=0000.
    - exp_reg<=expected, idx<=0, {x1,x0}<=00, cnt<=SETTLE-1.
    - Go to WAIT.
- WAIT:
  - If cnt!=0: cnt<=cnt-1; x1,x0 held.
  - If cnt==0: table_out[idx]<=z.
    - If idx<3: idx<=idx+1, {x1,x0}<=idx+1, cnt<=SETTLE-1.
    - If idx==3: {x1,x0}<=00, eoc<=1, pass<=({z,table_out[2:0]}==exp_reg), go to DONE.
  - The pass compare uses the bit being written this cycle, not the stale register value.
- DONE:
  - eoc=1; table_out and pass are stable.
  - Stays in DONE while soc=1; goes to IDLE on the first edge with soc=0.
  - Holding soc high never retriggers a run; a new run needs soc to drop and rise again.
- Latency:
  - Start edge to eoc=1 is exactly 4*SETTLE clock edges.
  - SETTLE=2: eoc rises on the 8th edge after the start edge.
  - SETTLE=1: eoc rises on the 4th edge after the start edge.
- Each combination is driven for exactly SETTLE cycles. z is sampled on the last edge of that window.
- Changes on expected after the start edge are ignored until the next start.
- soc changes during WAIT are ignored.
- Counter and index widths are sized for the parameter range; idx never wraps past 3.
- Reference tables for bench use (bit3..bit0): AND=1000, OR=1110, NAND=0111, NOR=0001, XOR=0110.

Test Plan:
- Nominal AND: SETTLE=2, gate=AND, expected=1000, soc pulsed 1 for one cycle -> x1x0 sequence 00,01,10,11 with 2 cycles each; eoc=0 for 8 cycles then 1; table_out=1000, pass=1.
- Wrong expectation: gate=AND, expected=1110 -> table_out=1000, pass=0, eoc=1 after 8 cycles.
- Minimum settle and other gate: SETTLE=1, gate=XOR, expected=0110 -> eoc returns to 1 after 4 edges; table_out=0110, pass=1.
- Handshake: soc held 1 for 20 cycles across a run -> exactly one run; DONE is held with eoc=1. Drop soc for 1 cycle, then raise -> second run starts; table_out cleared to 0000 at its start.
- Reset mid-run: assert reset during WAIT with idx=2 -> eoc=1, x1=x0=0, table_out=0000, pass=0 asynchronously. After release, a new soc gives a complete correct run.
- Mid-run input changes: expected changed from 1000 to 0000 during WAIT, and z forced to a stuck-at-0 gate model -> table_out=0000, pass=0, because the latched 1000 is used.

Source files
------------

// File: rtl/gate_truth_table_sequencer_if.sv
// Bundle between the test/control unit (soc/eoc, expected, results) and the gate under exercise (x1/x0/z).
// The slave modport is the sequencer itself; the master side represents everything around it.
interface gate_truth_table_sequencer_if;
  logic       soc;
  logic       eoc;
  logic [3:0] expected;
  logic       x1;
  logic       x0;
  logic       z;
  logic [3:0] table_out;
  logic       pass;

  modport master (
    output soc,
    output expected,
    output z,
    input  eoc,
    input  x1,
    input  x0,
    input  table_out,
    input  pass
  );

  modport slave (
    input  soc,
    input  expected,
    input  z,
    output eoc,
    output x1,
    output x0,
    output table_out,
    output pass
  );
endinterface

// File: rtl/gate_truth_table_sequencer.sv
// Steps a 2-input gate through 00,01,10,11, holds each combination SETTLE cycles,
// samples z on the last cycle, and compares the 4-bit table with the expectation latched at start.
module gate_truth_table_sequencer #(
  parameter int unsigned SETTLE = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  gate_truth_table_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] idx_q, idx_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] tab_q, tab_d;
  logic [3:0] exp_q, exp_d;
  logic       pass_q, pass_d;
  logic       eoc_q, eoc_d;
  logic [3:0] tab_sampled;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sel_q   <= '0;
      tab_q   <= '0;
      exp_q   <= '0;
      pass_q  <= 1'b0;
      eoc_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      tab_q   <= tab_d;
      exp_q   <= exp_d;
      pass_q  <= pass_d;
      eoc_q   <= eoc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    tab_d   = tab_q;
    exp_d   = exp_q;
    pass_d  = pass_q;
    eoc_d   = eoc_q;

    // Table including the bit captured this edge, so the final compare sees the fresh z.
    tab_sampled        = tab_q;
    tab_sampled[idx_q] = bus.z;

    unique case (state_q)
      IDLE: begin
        if (bus.soc) begin
          eoc_d   = 1'b0;
          pass_d  = 1'b0;
          tab_d   = '0;
          exp_d   = bus.expected;
          idx_d   = '0;
          sel_d   = '0;
          cnt_d   = CNT_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          tab_d = tab_sampled;
          if (idx_q != 2'd3) begin
            idx_d = idx_q + 2'd1;
            sel_d = idx_q + 2'd1;
            cnt_d = CNT_LOAD;
          end else begin
            sel_d   = '0;
            eoc_d   = 1'b1;
            pass_d  = (tab_sampled == exp_q);
            state_d = DONE;
          end
        end
      end
      DONE: begin
        // A held soc parks here; only a low soc re-arms the start detector in IDLE.
        if (!bus.soc) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.eoc       = eoc_q;
  assign bus.x1        = sel_q[1];
  assign bus.x0        = sel_q[0];
  assign bus.table_out = tab_q;
  assign bus.pass      = pass_q;

endmodule

// File: tb/tb_gate_truth_table_sequencer.sv
// Bench for gate_truth_table_sequencer: two instances (SETTLE=2 and SETTLE=1) driving behavioural gate models.
module tb_gate_truth_table_sequencer;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  gate_truth_table_sequencer_if bus_a ();
  gate_truth_table_sequencer_if bus_b ();

  gate_truth_table_sequencer #(.SETTLE(2)) dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  gate_truth_table_sequencer #(.SETTLE(1)) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  logic [1:0]      soc_v;
  logic [1:0][3:0] exp_v;
  logic [1:0][3:0] gate_v;

  assign bus_a.soc      = soc_v[0];
  assign bus_b.soc      = soc_v[1];
  assign bus_a.expected = exp_v[0];
  assign bus_b.expected = exp_v[1];
  assign bus_a.z        = gate_v[0][{bus_a.x1, bus_a.x0}];
  assign bus_b.z        = gate_v[1][{bus_b.x1, bus_b.x0}];

  logic [1:0]      eoc_w;
  logic [1:0][1:0] x_w;
  logic [1:0][3:0] tab_w;
  logic [1:0]      pass_w;

  assign eoc_w  = {bus_b.eoc, bus_a.eoc};
  assign x_w    = {{bus_b.x1, bus_b.x0}, {bus_a.x1, bus_a.x0}};
  assign tab_w  = {bus_b.table_out, bus_a.table_out};
  assign pass_w = {bus_b.pass, bus_a.pass};

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, want);
    end
  endtask

  function automatic int settle_of(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  // One complete run from IDLE; checks the drive sequence and latency on the way.
  task automatic do_run(input int d, input logic [3:0] gate, input logic [3:0] expv,
                        input bit change_exp, input logic [3:0] late_exp,
                        output logic [3:0] got_tab, output logic got_pass);
    int s;
    s = settle_of(d);
    gate_v[d] = gate;
    exp_v[d]  = expv;
    soc_v[d]  = 1'b1;
    @(posedge clock); #1;
    soc_v[d] = 1'b0;
    for (int k = 0; k < 4 * s; k++) begin
      chk("run_eoc_low", 4'(eoc_w[d]), 4'd0);
      chk("run_x_seq", 4'(x_w[d]), 4'(k / s));
      if (k == 1 && change_exp) exp_v[d] = late_exp;
      @(posedge clock); #1;
    end
    chk("run_eoc_done", 4'(eoc_w[d]), 4'd1);
    chk("run_x_done", 4'(x_w[d]), 4'd0);
    got_tab  = tab_w[d];
    got_pass = pass_w[d];
    // DONE -> IDLE with soc low; results must stay put.
    @(posedge clock); #1;
    chk("idle_eoc", 4'(eoc_w[d]), 4'd1);
    chk("idle_tab_hold", tab_w[d], got_tab);
  endtask

  typedef struct {
    int         d;
    logic [3:0] gate;
    logic [3:0] expv;
    logic [3:0] want_tab;
    logic       want_pass;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [3:0] t;
    logic       p;

    vecs[0] = '{0, 4'b1000, 4'b1000, 4'b1000, 1'b1};  // AND nominal
    vecs[1] = '{0, 4'b1000, 4'b1110, 4'b1000, 1'b0};  // AND, wrong expectation
    vecs[2] = '{1, 4'b0110, 4'b0110, 4'b0110, 1'b1};  // XOR, SETTLE=1
    vecs[3] = '{0, 4'b1110, 4'b1110, 4'b1110, 1'b1};  // OR
    vecs[4] = '{1, 4'b0111, 4'b0111, 4'b0111, 1'b1};  // NAND
    vecs[5] = '{0, 4'b0001, 4'b0001, 4'b0001, 1'b1};  // NOR
    vecs[6] = '{1, 4'b0110, 4'b1001, 4'b0110, 1'b0};  // XOR vs XNOR
    vecs[7] = '{1, 4'b1000, 4'b0111, 4'b1000, 1'b0};  // AND vs NAND

    reset  = 1'b1;
    soc_v  = '0;
    exp_v  = '0;
    gate_v = '0;
    @(posedge clock); @(posedge clock); #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset_eoc", 4'(eoc_w[d]), 4'd1);
      chk("reset_x", 4'(x_w[d]), 4'd0);
      chk("reset_tab", tab_w[d], 4'd0);
      chk("reset_pass", 4'(pass_w[d]), 4'd0);
    end
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    chk("idle_after_reset", 4'(eoc_w[0]), 4'd1);

    for (int i = 0; i < 8; i++) begin
      do_run(vecs[i].d, vecs[i].gate, vecs[i].expv, 1'b0, 4'd0, t, p);
      chk("vec_table", t, vecs[i].want_tab);
      chk("vec_pass", 4'(p), 4'(vecs[i].want_pass));
    end

    // Expected changes mid-run against a stuck-at-0 gate: latched 1000 must win.
    do_run(0, 4'b0000, 4'b1000, 1'b1, 4'b0000, t, p);
    chk("stuck_table", t, 4'b0000);
    chk("stuck_pass", 4'(p), 4'd0);
    do_run(0, 4'b1000, 4'b1000, 1'b1, 4'b0000, t, p);
    chk("late_exp_pass", 4'(p), 4'd1);

    // soc held high across a run: exactly one run, DONE held.
    gate_v[0] = 4'b1000;
    exp_v[0]  = 4'b1000;
    soc_v[0]  = 1'b1;
    for (int n = 0; n <= 20; n++) begin
      @(posedge clock); #1;
      chk("hold_eoc", 4'(eoc_w[0]), (n < 8) ? 4'd0 : 4'd1);
      if (n >= 8) chk("hold_tab", tab_w[0], 4'b1000);
    end
    soc_v[0] = 1'b0;
    @(posedge clock); #1;
    chk("drop_eoc", 4'(eoc_w[0]), 4'd1);
    soc_v[0] = 1'b1;
    @(posedge clock); #1;
    chk("restart_eoc", 4'(eoc_w[0]), 4'd0);
    chk("restart_tab_clr", tab_w[0], 4'b0000);
    chk("restart_pass_clr", 4'(pass_w[0]), 4'd0);
    soc_v[0] = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clock); #1;
    end
    chk("restart_done_eoc", 4'(eoc_w[0]), 4'd1);
    chk("restart_done_tab", tab_w[0], 4'b1000);
    chk("restart_done_pass", 4'(pass_w[0]), 4'd1);
    @(posedge clock); #1;

    // Asynchronous reset while idx=2 on the SETTLE=2 instance.
    gate_v[0] = 4'b1110;
    exp_v[0]  = 4'b1110;
    soc_v[0]  = 1'b1;
    @(posedge clock); #1;
    soc_v[0] = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      @(posedge clock); #1;
    end
    chk("midrun_tab", tab_w[0], 4'b0010);
    chk("midrun_x", 4'(x_w[0]), 4'd2);
    #1 reset = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("async_eoc", 4'(eoc_w[d]), 4'd1);
      chk("async_x", 4'(x_w[d]), 4'd0);
      chk("async_tab", tab_w[d], 4'd0);
      chk("async_pass", 4'(pass_w[d]), 4'd0);
    end
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    do_run(0, 4'b1110, 4'b1110, 1'b0, 4'd0, t, p);
    chk("post_reset_table", t, 4'b1110);
    chk("post_reset_pass", 4'(p), 4'd1);

    // Random gates and expectations: the table is the gate's function, pass is equality with the start-time expectation.
    for (int i = 0; i < 30; i++) begin
      int         d;
      logic [3:0] g, e, late;
      bit         chg;
      d    = int'($urandom_range(0, 1));
      g    = 4'($urandom);
      e    = ($urandom_range(0, 1) == 1) ? g : 4'($urandom);
      chg  = 1'($urandom_range(0, 1));
      late = 4'($urandom);
      do_run(d, g, e, chg, late, t, p);
      chk("rand_table", t, g);
      chk("rand_pass", 4'(p), 4'(g == e));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
